power_controller: RTL and testbench
===================================

# power_controller

Sequencing controller that computes `base^exp` modulo 256 by driving the shared shift-add `Multiplier` through repeated multiply and square requests. It uses right-to-left square-and-multiply. It sits between the calculator's operation-select logic and the `Multiplier` instance. Operands are held stable on the multiplier's `A`/`B`/`sel` inputs for each request, and each product is collected on `done`.

## Interface
Parameters:
- `EXP_W`, 4: width of the exponent operand.
- `TIMEOUT_CYC`, 64: maximum number of wait cycles per multiplier request. Only used when `POWER_TIMEOUT_EN` is defined.

Ports:
- `clk` input 1: system clock. All state updates on the rising edge.
- `CLR` input 1: reset. Asynchronous, active-high.
- `start` input 1: request a new power operation. Sampled only in IDLE.
- `base` input 8: base operand. Captured on an accepted start.
- `exp` input `EXP_W`: exponent. Captured on an accepted start.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when `result` becomes valid.
- `result` output 8: `base^exp mod 256`. Held until the next accepted start.
- `err` output 1: set when the operation was aborted by timeout.
- `ops` output 4: number of multiplier requests issued by the last operation.
- `mul_enter` output 1: request pulse to the Multiplier.
- `mul_sel` output 2: `2'b00` multiply A*B, `2'b01` square A.
- `mul_a` output 8: Multiplier A operand.
- `mul_b` output 8: Multiplier B operand.
- `mul_p` input 8: Multiplier product.
- `mul_done` input 1: Multiplier completion.

## Operation
- Internal registers: `r` (result accumulator), `b` (running square), `e` (remaining exponent).
- States: IDLE, CHECK, MUL_ISSUE, MUL_WAIT, SQR_ISSUE, SQR_WAIT, DONE.
- IDLE:
  - `start=1` → load `b←base`, `e←exp`, `r←1`, `ops←0`, `err←0`.
  - Next state is CHECK.
- CHECK:
  - `e==0` → DONE.
  - `e[0]=1` → MUL_ISSUE.
  - Otherwise → `e←e>>1`, then SQR_ISSUE.
- MUL_ISSUE and SQR_ISSUE each last exactly one cycle.
  - `mul_enter=1` in that cycle.
  - `ops` increments, saturating at 15.
  - Next state is the matching WAIT state.
- MUL_WAIT, on `mul_done=1`:
  - Capture `r←mul_p` and `e←e>>1`.
  - Next is DONE if the shifted `e==0`, else SQR_ISSUE. No trailing square is issued.
- SQR_WAIT, on `mul_done=1`: capture `b←mul_p`, then CHECK.
- DONE lasts one cycle, then IDLE unconditionally.
- Operand drive:
  - MUL_ISSUE/MUL_WAIT: `mul_a=r`, `mul_b=b`, `sel=00`.
  - SQR_ISSUE/SQR_WAIT: `mul_a=b`, `mul_b=b`, `sel=01`.
  - All other states: `mul_a`, `mul_b` and `mul_sel` are 0.
- Arithmetic is 8-bit truncated throughout; wraps mod 256 silently. `0^0 = 1`.
- `mul_done` is ignored outside the WAIT states, including the ISSUE cycle.

## Timing
- All outputs reset to 0.
- `start` accepted at edge k: CHECK at k+1. For `exp=0`, `done` is high in cycle k+2.
- Each multiplier request costs 1 issue cycle plus L wait cycles, where L is the Multiplier latency (edge of enter to `done` seen).
- `busy` is high in every state except IDLE and DONE.
- `done` is high only in DONE.
- `result` updates at the edge entering DONE.
- `start` is ignored while busy and in DONE; there is no queuing.
- `CLR` mid-operation:
  - Immediately returns to IDLE.
  - `mul_enter` drops asynchronously.
  - An in-flight `mul_done` is ignored.
- Operands on `mul_a`/`mul_b`/`mul_sel` are stable from the ISSUE cycle through the `mul_done` edge.

## Configuration
- `POWER_TIMEOUT_EN` defined:
  - A wait counter clears on entry to each WAIT state.
  - If it reaches `TIMEOUT_CYC` without `mul_done`: go to DONE with `err=1` and `result=0`.
- Not defined:
  - The WAIT states wait indefinitely.
  - `err` is tied 0 and no counter is built.

## Structure
- Package `power_pkg`:
  - state enum `power_state_t`
  - constants `SEL_MUL=2'b00`, `SEL_SQR=2'b01`, `RESULT_ONE=8'd1`
- Sub-module `wait_timer`:
  - Clearable up-counter with a terminal flag.
  - Instantiated only under `POWER_TIMEOUT_EN`.

## Test plan
- `base=3`, `exp=13` with the real Multiplier → `result=211`, `ops=6`, single `done` pulse, `err=0`.
- `base=5`, `exp=0` → `done` two cycles after the start edge, `result=1`, `ops=0`, `mul_enter` never asserted.
- `base=2`, `exp=8` → `result=0` (wraps), `ops=4`. `base=7`, `exp=2` → `result=49`, `ops=2`.
- `start` pulsed during MUL_WAIT, then a spurious `mul_done` in IDLE → both ignored, result unchanged.
- `CLR` asserted in SQR_WAIT, then a late `mul_done` → all outputs 0 immediately, stays IDLE, next start computes correctly.
- With `POWER_TIMEOUT_EN`, `TIMEOUT_CYC=8`, stub `mul_done` tied low → DONE after 8 wait cycles, `err=1`, `result=0`.

Source files
------------

// File: rtl/power_pkg.sv
// Shared types and constants for the square-and-multiply power controller.
package power_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_SQR_ISSUE,
    S_SQR_WAIT,
    S_DONE
  } power_state_t;

  localparam logic [1:0] SEL_MUL    = 2'b00;
  localparam logic [1:0] SEL_SQR    = 2'b01;
  localparam logic [7:0] RESULT_ONE = 8'd1;
  localparam logic [3:0] OPS_MAX    = 4'd15;

endpackage

// File: rtl/wait_timer.sv
// Clearable up-counter that flags the last permitted wait cycle.
// Only instantiated by power_controller when POWER_TIMEOUT_EN is defined.
module wait_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] count;

  // tc is raised during the LIMIT-th enabled cycle since the last clear
  assign tc = en && (count == CW'(LIMIT - 1));

  // Count enabled cycles; a clear restarts the window for the next request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/power_controller.sv
// base^exp mod 256 by right-to-left square-and-multiply, sequencing a shared
// shift-add Multiplier through multiply (r*b) and square (b*b) requests.
// Optional feature: define POWER_TIMEOUT_EN to abort a request that waits
// TIMEOUT_CYC cycles without mul_done (err=1, result=0).
module power_controller
  import power_pkg::*;
#(
  parameter int EXP_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic [7:0]       base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic             err,
  output logic [3:0]       ops,
  output logic             mul_enter,
  output logic [1:0]       mul_sel,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [7:0]       mul_p,
  input  logic             mul_done
);

  power_state_t     state, state_nx;
  logic [7:0]       r;        // result accumulator
  logic [7:0]       b;        // running square of base
  logic [EXP_W-1:0] e;        // remaining exponent bits
  logic [EXP_W-1:0] e_shr;
  logic             res_ld;
  logic [7:0]       res_val;
  logic             to_hit;
  logic             in_wait;

  assign e_shr   = e >> 1;
  assign in_wait = (state == S_MUL_WAIT) || (state == S_SQR_WAIT);
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);

`ifdef POWER_TIMEOUT_EN
  // The timer window restarts on every issue cycle, so each request gets its own budget
  wait_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk(clk),
    .rst(CLR),
    .clr(mul_enter),
    .en (in_wait),
    .tc (to_hit)
  );

  // err is cleared by an accepted start and set only by an abort
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      err <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      err <= 1'b0;
    end else if (in_wait && !mul_done && to_hit) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Next state, multiplier operand drive and result load selection
  always_comb begin
    state_nx  = state;
    mul_enter = 1'b0;
    mul_sel   = '0;
    mul_a     = '0;
    mul_b     = '0;
    res_ld    = 1'b0;
    res_val   = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (e == '0) begin
          state_nx = S_DONE;
          res_ld   = 1'b1;
          res_val  = r;
        end else if (e[0]) begin
          state_nx = S_MUL_ISSUE;
        end else begin
          state_nx = S_SQR_ISSUE;
        end
      end
      S_MUL_ISSUE: begin
        mul_enter = 1'b1;
        mul_sel   = SEL_MUL;
        mul_a     = r;
        mul_b     = b;
        state_nx  = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        mul_sel = SEL_MUL;
        mul_a   = r;
        mul_b   = b;
        if (mul_done) begin
          // the last set bit needs no trailing square
          if (e_shr == '0) begin
            state_nx = S_DONE;
            res_ld   = 1'b1;
            res_val  = mul_p;
          end else begin
            state_nx = S_SQR_ISSUE;
          end
        end else if (to_hit) begin
          state_nx = S_DONE;
          res_ld   = 1'b1;
          res_val  = '0;
        end
      end
      S_SQR_ISSUE: begin
        mul_enter = 1'b1;
        mul_sel   = SEL_SQR;
        mul_a     = b;
        mul_b     = b;
        state_nx  = S_SQR_WAIT;
      end
      S_SQR_WAIT: begin
        mul_sel = SEL_SQR;
        mul_a   = b;
        mul_b   = b;
        if (mul_done) begin
          state_nx = S_CHECK;
        end else if (to_hit) begin
          state_nx = S_DONE;
          res_ld   = 1'b1;
          res_val  = '0;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Control state and visible outputs; CLR abandons any in-flight request
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state  <= S_IDLE;
      result <= '0;
      ops    <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && start) begin
        ops <= '0;
      end else if (mul_enter && (ops != OPS_MAX)) begin
        ops <= ops + 4'd1;
      end
      if (res_ld) begin
        result <= res_val;
      end
    end
  end

  // Working registers: loaded on start, updated as products come back
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          r <= RESULT_ONE;
          b <= base;
          e <= exp;
        end
      end
      S_CHECK: begin
        if ((e != '0) && !e[0]) e <= e_shr;
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          r <= mul_p;
          e <= e_shr;
        end
      end
      S_SQR_WAIT: begin
        if (mul_done) b <= mul_p;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_power_controller.sv
// Self-checking bench for power_controller with a behavioural multiplier model.
module tb_power_controller;
  import power_pkg::*;

  localparam int EXP_W = 4;
`ifdef POWER_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif

  logic             clk   = 1'b0;
  logic             CLR   = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       base  = '0;
  logic [EXP_W-1:0] exp   = '0;
  logic             busy, done, err, mul_enter, mul_done;
  logic [7:0]       result, mul_a, mul_b, mul_p;
  logic [3:0]       ops;
  logic [1:0]       mul_sel;

  power_controller #(
    .EXP_W(EXP_W),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .CLR(CLR), .start(start), .base(base), .exp(exp),
    .busy(busy), .done(done), .result(result), .err(err), .ops(ops),
    .mul_enter(mul_enter), .mul_sel(mul_sel), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- multiplier model: latency lat from enter edge to done edge
  int         lat = 3;
  int         cnt = 0;
  logic [7:0] m_a = '0, m_b = '0, m_p = '0;
  logic [1:0] m_sel = '0;
  logic       suppress = 1'b0;
  logic       spur = 1'b0;

  always @(posedge clk) begin
    logic [15:0] full;
    full = (mul_sel == SEL_SQR) ? mul_a * mul_a : mul_a * mul_b;
    if (mul_enter) begin
      m_a   <= mul_a;
      m_b   <= mul_b;
      m_sel <= mul_sel;
      m_p   <= full[7:0];
      cnt   <= lat;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  assign mul_p    = m_p;
  assign mul_done = ((cnt == 1) && !suppress) || spur;

  // ---------------- scoreboard and monitors
  typedef struct {
    int res;
    int ops;
    int err;
    int enters;
  } exp_t;
  exp_t sbq[$];

  int   enters = 0;
  int   ndone = 0;
  int   busy_cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) if (mul_enter) enters++;

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (busy && (cnt == 1) && !suppress) begin
      chk("operand_a_stable", int'(mul_a), int'(m_a));
      chk("operand_b_stable", int'(mul_b), int'(m_b));
      chk("operand_sel_stable", int'(mul_sel), int'(m_sel));
    end
    if (done) begin
      ndone++;
      chk("done_single_pulse", int'(prev_done), 0);
      chk("done_expected", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        exp_t x;
        x = sbq.pop_front();
        chk("result", int'(result), x.res);
        chk("ops", int'(ops), x.ops);
        chk("err", int'(err), x.err);
        chk("mul_enter_pulses", enters, x.enters);
        chk("busy_low_in_done", int'(busy), 0);
      end
    end
    prev_done = done;
  end

  // ---------------- reference model (plain repeated multiplication)
  function automatic int ref_pow(input int bb, input int ee);
    int rr = 1;
    for (int i = 0; i < ee; i++) rr = (rr * bb) % 256;
    return rr;
  endfunction

  function automatic int ref_ops(input int ee);
    int n = 0;
    int hi = -1;
    for (int i = 0; i < EXP_W; i++) begin
      if (ee[i]) begin
        n++;
        hi = i;
      end
    end
    if (hi < 0) return 0;
    return (n + hi > 15) ? 15 : n + hi;
  endfunction

  task automatic push(input int r, input int o, input int er, input int en);
    exp_t x;
    x.res = r; x.ops = o; x.err = er; x.enters = en;
    sbq.push_back(x);
  endtask

  task automatic launch(input logic [7:0] bb, input logic [EXP_W-1:0] ee);
    @(negedge clk);
    base = bb; exp = ee; start = 1'b1;
    enters = 0; busy_cyc = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string name);
    for (int k = 0; k < 600; k++) begin
      if (ndone != n0) break;
      @(negedge clk);
    end
    chk({name, "_completed"}, int'(ndone != n0), 1);
  endtask

  task automatic run_op(input logic [7:0] bb, input logic [EXP_W-1:0] ee,
                        input int r, input int o, input int er);
    int n0;
    n0 = ndone;
    push(r, o, er, o);
    launch(bb, ee);
    wait_done(n0, "op");
  endtask

  typedef struct {
    logic [7:0]       b;
    logic [EXP_W-1:0] e;
    int               res;
    int               ops;
    int               lat;
  } vec_t;
  vec_t vt[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int ok;
    vt[0] = '{8'd3,   4'd13, 211, 6, 3};
    vt[1] = '{8'd2,   4'd8,  0,   4, 2};
    vt[2] = '{8'd7,   4'd2,  49,  2, 1};
    vt[3] = '{8'd0,   4'd0,  1,   0, 4};
    vt[4] = '{8'd255, 4'd15, 255, 7, 2};
    vt[5] = '{8'd0,   4'd5,  0,   4, 5};
    vt[6] = '{8'd16,  4'd2,  0,   2, 1};
    vt[7] = '{8'd1,   4'd9,  1,   5, 3};
    vt[8] = '{8'd3,   4'd4,  81,  3, 2};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", int'({busy, done, err, mul_enter}), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_ops", int'(ops), 0);
    chk("reset_operands", int'({mul_sel, mul_a, mul_b}), 0);
    CLR = 1'b0;

    // exp=0: done exactly two cycles after the start edge, no requests
    n0 = ndone;
    push(1, 0, 0, 0);
    @(negedge clk);
    base = 8'd5; exp = '0; start = 1'b1; enters = 0;
    @(negedge clk);
    start = 1'b0;
    chk("exp0_busy_k1", int'(busy), 1);
    chk("exp0_done_k1", int'(done), 0);
    @(negedge clk);
    chk("exp0_done_k2", int'(done), 1);
    chk("exp0_result_k2", int'(result), 1);
    @(negedge clk);
    chk("exp0_idle_after", int'({busy, done}), 0);
    wait_done(n0, "exp0");

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      lat = vt[i].lat;
      run_op(vt[i].b, vt[i].e, vt[i].res, vt[i].ops, 0);
    end

    // random operands checked against the reference model
    for (int i = 0; i < 6; i++) begin
      logic [7:0]       rb;
      logic [EXP_W-1:0] re;
      rb  = 8'($urandom);
      re  = EXP_W'($urandom);
      lat = $urandom_range(1, 5);
      run_op(rb, re, ref_pow(int'(rb), int'(re)), ref_ops(int'(re)), 0);
    end

    // start pulsed during MUL_WAIT is ignored; spurious mul_done in IDLE is ignored
    lat = 8;
    n0 = ndone;
    push(3, 1, 0, 1);
    launch(8'd3, 4'd1);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy && !mul_enter && (enters == 1)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_mul_wait", ok, 1);
    base = 8'd9; exp = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, "start_in_wait");
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_idle", int'({busy, done, mul_enter}), 0);
    chk("spur_result_held", int'(result), 3);
    chk("spur_ops_held", int'(ops), 1);
    repeat (3) @(negedge clk);
    chk("spur_still_idle", int'(busy), 0);

    // CLR during SQR_WAIT, then the late product arrives
    lat = 6;
    push(49, 2, 0, 2);
    launch(8'd7, 4'd2);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy && !mul_enter && (mul_sel == SEL_SQR)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_sqr_wait", ok, 1);
    CLR = 1'b1;
    #1;
    chk("clr_ctrl_zero", int'({busy, done, err, mul_enter}), 0);
    chk("clr_result_ops_zero", int'({result, ops}), 0);
    chk("clr_operands_zero", int'({mul_sel, mul_a, mul_b}), 0);
    void'(sbq.pop_back());
    @(negedge clk);
    CLR = 1'b0;
    n0 = ndone;
    repeat (12) @(negedge clk);
    chk("clr_stays_idle", int'({busy, done, mul_enter}), 0);
    chk("clr_no_done", ndone, n0);
    chk("clr_result_zero", int'(result), 0);
    lat = 3;
    run_op(8'd7, 4'd2, 49, 2, 0);

`ifdef POWER_TIMEOUT_EN
    // multiplier never answers: abort after TO_CYC wait cycles
    suppress = 1'b1;
    n0 = ndone;
    push(0, 1, 1, 1);
    launch(8'd3, 4'd1);
    wait_done(n0, "timeout");
    chk("timeout_busy_cycles", busy_cyc, 2 + TO_CYC);
    repeat (4) @(negedge clk);
    suppress = 1'b0;
    run_op(8'd2, 4'd3, 8, 3, 0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
